// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side controller of an asynchronous FIFO. It tracks the binary read
//   pointer, publishes it in Gray code to the write domain, and fetches words
//   from a FIFO memory that has one cycle of read latency. Fetched words land
//   in a 2-entry output buffer that drives a valid/ready stream. Fetches are
//   issued early enough to sustain one word per cycle.
//
// Ports
//   R_CLK        read-domain clock, all state on the rising edge
//   R_RST        synchronous active-high reset
//   rq2_wptr     Gray write pointer, already synchronized into R_CLK
//   Rd_data_mem  memory read data, valid the cycle after Rclken
//   Rclken       memory read strobe, one word per strobe
//   Raddr        memory read address
//   Rptr         registered Gray read pointer for the write domain
//   EMPTY        no unfetched words left in memory
//   RD_DATA      head word of the output buffer
//   RD_VALID     RD_DATA is valid
//   RD_READY     consumer accepts RD_DATA
//   RD_LEVEL     registered count of unfetched words, 0..DEPTH
module fifo_rd_ctrl #(
  parameter int DEPTH  = 8,
  parameter int P_SIZE = 4,
  parameter int D_SIZE = 8
) (
  input  logic              R_CLK,
  input  logic              R_RST,
  input  logic [P_SIZE-1:0] rq2_wptr,
  input  logic [D_SIZE-1:0] Rd_data_mem,
  output logic              Rclken,
  output logic [P_SIZE-2:0] Raddr,
  output logic [P_SIZE-1:0] Rptr,
  output logic              EMPTY,
  output logic [D_SIZE-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [P_SIZE-1:0] RD_LEVEL
);

  // The pointer carries one wrap bit above the address bits.
  if (DEPTH != (1 << (P_SIZE - 1))) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must equal 2**(P_SIZE-1)");
  end

  logic [P_SIZE-1:0] rbin_q, rbin_d;
  logic [P_SIZE-1:0] rptr_q, rptr_d;
  logic [P_SIZE-1:0] level_q, level_d;
  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic [D_SIZE-1:0] buf0_q, buf0_d;
  logic [D_SIZE-1:0] buf1_q, buf1_d;

  logic       pop;
  logic       fetch;
  logic [1:0] occ_mid;
  logic [2:0] demand;

  function automatic logic [P_SIZE-1:0] gray2bin(input logic [P_SIZE-1:0] g);
    logic [P_SIZE-1:0] b;
    b[P_SIZE-1] = g[P_SIZE-1];
    for (int i = P_SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    EMPTY    = (rptr_q == rq2_wptr);
    // Reset hides any buffered word in the reset cycle itself.
    RD_VALID = (occ_q != 2'd0) && !R_RST;
    RD_DATA  = buf0_q;
    pop      = RD_VALID && RD_READY;

    // Words that will occupy the buffer next cycle if nothing new is fetched;
    // a new fetch is allowed only if that leaves room for its capture.
    demand = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    fetch  = !R_RST && !EMPTY && (demand < 3'd2);

    Rclken   = fetch;
    Raddr    = rbin_q[P_SIZE-2:0];
    Rptr     = rptr_q;
    RD_LEVEL = level_q;

    rbin_d  = rbin_q + {{(P_SIZE-1){1'b0}}, fetch};
    rptr_d  = rbin_d ^ (rbin_d >> 1);
    level_d = gray2bin(rq2_wptr) - rbin_q;
    infl_d  = fetch;

    // Pop shifts the buffer first; the in-flight word then fills the first
    // free slot, so a same-cycle capture and pop both take effect.
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    occ_mid = occ_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (infl_q) begin
      if (occ_mid == 2'd0) begin
        buf0_d = Rd_data_mem;
      end else begin
        buf1_d = Rd_data_mem;
      end
    end
    occ_d = occ_mid + {1'b0, infl_q};
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      occ_q   <= 2'd0;
      infl_q  <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
    end
  end

  // Buffer contents are only meaningful under occ_q, so they need no reset.
  always_ff @(posedge R_CLK) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule
